// File: rtl/vram_arbiter_pkg.sv
// Shared definitions for the VRAM arbiter: FSM state encoding, statistics
// counter widths and the slot-counter width helper.
package vram_arbiter_pkg;

   typedef enum logic [2:0] {
      ARB_IDLE,
      ARB_WAIT,
      ARB_DATA,
      ARB_DONE,
      ARB_HOLD
   } arb_state_e;

   localparam int STAT_STEALS_W = 16;
   localparam int STAT_WAIT_W   = 8;

   function automatic int slot_w(input int period);
      return (period > 1) ? $clog2(period) : 1;
   endfunction

endpackage

// File: rtl/vram_arbiter_stats.sv
// Optional arbiter statistics: saturating count of video slots stolen by the
// CPU and the longest CPU wait, in cycles, from request to grant.
module vram_arb_stats
   import vram_arbiter_pkg::*;
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     grant,
   input  logic                     vid_req,
   input  logic                     wait_start,
   input  logic                     in_wait,
   output logic [STAT_STEALS_W-1:0] stat_steals,
   output logic [STAT_WAIT_W-1:0]   stat_max_wait
);

   logic [STAT_STEALS_W-1:0] steals_q, steals_d;
   logic [STAT_WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [STAT_WAIT_W-1:0]   max_wait_q, max_wait_d;
   logic [STAT_WAIT_W-1:0]   cur_wait;

   always_comb begin
      steals_d   = steals_q;
      wait_cnt_d = wait_cnt_q;
      max_wait_d = max_wait_q;
      // A grant straight from IDLE waited zero cycles.
      cur_wait   = in_wait ? wait_cnt_q : '0;

      if (grant && vid_req && (steals_q != '1))
         steals_d = steals_q + STAT_STEALS_W'(1);

      if (grant) begin
         wait_cnt_d = '0;
         if (cur_wait > max_wait_q)
            max_wait_d = cur_wait;
      end else if (wait_start) begin
         wait_cnt_d = STAT_WAIT_W'(1);
      end else if (in_wait && (wait_cnt_q != '1)) begin
         wait_cnt_d = wait_cnt_q + STAT_WAIT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         steals_q   <= '0;
         wait_cnt_q <= '0;
         max_wait_q <= '0;
      end else begin
         steals_q   <= steals_d;
         wait_cnt_q <= wait_cnt_d;
         max_wait_q <= max_wait_d;
      end
   end

   assign stat_steals   = steals_q;
   assign stat_max_wait = max_wait_q;

endmodule

// File: rtl/vram_arbiter.sv
// Shares one synchronous VRAM port between the video fetcher (default owner)
// and the CPU (req/ack). Define VRAM_ARBITER_STATS_EN to build the statistics counters.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int ADDR_W          = 16,
   parameter int DATA_W          = 8,
   parameter int CPU_SLOT_PERIOD = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     vid_req,
   input  logic [ADDR_W-1:0]        vid_addr,
   output logic [DATA_W-1:0]        vid_data,
   output logic                     vid_valid,
   input  logic                     cpu_req,
   input  logic                     cpu_we,
   input  logic [ADDR_W-1:0]        cpu_addr,
   input  logic [DATA_W-1:0]        cpu_wdata,
   output logic [DATA_W-1:0]        cpu_rdata,
   output logic                     cpu_ack,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic                     mem_we,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic [DATA_W-1:0]        mem_rdata,
   output logic [STAT_STEALS_W-1:0] stat_steals,
   output logic [STAT_WAIT_W-1:0]   stat_max_wait
);

   localparam int              SLOT_W    = slot_w(CPU_SLOT_PERIOD);
   localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(CPU_SLOT_PERIOD - 1);

   arb_state_e        state_q, state_d;
   logic [SLOT_W-1:0] slot_q, slot_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] vid_hold_q, vid_hold_d;
   logic              vid_own_q, vid_own_d;
   logic              cpu_pending;
   logic              grant;

   always_comb begin
      // NOTE: every signal gets a default before any branch, so no latch can be inferred.
      slot_d      = (slot_q == LAST_SLOT) ? '0 : slot_q + SLOT_W'(1);
      state_d     = state_q;
      we_d        = we_q;
      cpu_rdata_d = cpu_rdata_q;

      cpu_pending = ((state_q == ARB_IDLE) && cpu_req) || (state_q == ARB_WAIT);
      // Gated by reset so no write strobe can escape while reset is held.
      grant       = cpu_pending && ((slot_q == LAST_SLOT) || !vid_req) && !reset;

      mem_addr  = grant ? cpu_addr : vid_addr;
      mem_we    = grant && cpu_we;
      mem_wdata = cpu_wdata;

      vid_own_d  = vid_req && !grant;
      vid_data   = vid_own_q ? mem_rdata : vid_hold_q;
      vid_hold_d = vid_data;

      if (grant)
         we_d = cpu_we;

      case (state_q)
         ARB_IDLE: if (cpu_req) state_d = grant ? ARB_DATA : ARB_WAIT;
         ARB_WAIT: if (grant) state_d = ARB_DATA;
         ARB_DATA: begin
            if (!we_q)
               cpu_rdata_d = mem_rdata;
            state_d = ARB_DONE;
         end
         // A request still high after its ack is parked until released.
         ARB_DONE: state_d = cpu_req ? ARB_HOLD : ARB_IDLE;
         ARB_HOLD: if (!cpu_req) state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ARB_IDLE;
         slot_q      <= '0;
         we_q        <= 1'b0;
         cpu_rdata_q <= '0;
         vid_hold_q  <= '0;
         vid_own_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         we_q        <= we_d;
         cpu_rdata_q <= cpu_rdata_d;
         vid_hold_q  <= vid_hold_d;
         vid_own_q   <= vid_own_d;
      end
   end

   assign cpu_ack   = (state_q == ARB_DONE);
   assign cpu_rdata = cpu_rdata_q;
   assign vid_valid = vid_own_q;

`ifdef VRAM_ARBITER_STATS_EN
   logic wait_start;
   logic in_wait;

   assign wait_start = (state_q == ARB_IDLE) && cpu_req && !grant;
   assign in_wait    = (state_q == ARB_WAIT);

   vram_arb_stats u_stats (
      .clk           (clk),
      .reset         (reset),
      .grant         (grant),
      .vid_req       (vid_req),
      .wait_start    (wait_start),
      .in_wait       (in_wait),
      .stat_steals   (stat_steals),
      .stat_max_wait (stat_max_wait)
   );
`else
   assign stat_steals   = '0;
   assign stat_max_wait = '0;
`endif

endmodule
